vx_tex_dcr_writer: RTL and testbench
====================================

Name: VX_tex_dcr_writer

Overview:
- DCR bus master that turns one texture-stage configuration request into the ordered DCR write burst the texture unit's DCR slave expects.
- Sits between the command/CSR front-end and the DCR bus feeding the texture units.
- Accepts a full stage descriptor over valid/ready and serializes it: STAGE select, then ADDR, FORMAT, FILTER, WRAP, LOGDIM, MIPOFF(0..VX_TEX_LOD_MAX).
- Issues one write per cycle.

Parameters:
- INSTANCE_ID, "", trace/debug instance name.
- NUM_STAGES, 1, number of texture stages addressable; stage index width is CLOG2(NUM_STAGES), minimum 1.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  descriptor valid
- req_ready  output  1  writer can accept a descriptor
- req_stage  input  CLOG2(NUM_STAGES)  target stage
- req_baseaddr  input  TEX_ADDR_BITS  texture base address
- req_format  input  TEX_FORMAT_BITS  texel format
- req_filter  input  TEX_FILTER_BITS  filter mode
- req_wraps  input  2 x TEX_WRAP_BITS  wrap modes [0]=u, [1]=v
- req_logdims  input  2 x VX_TEX_LOD_BITS  log2 dims [0]=u, [1]=v
- req_mipoffs  input  (VX_TEX_LOD_MAX+1) x TEX_MIPOFF_BITS  mip offsets
- dcr_bus_if  VX_dcr_bus_if.master  write_valid/write_addr/write_data  DCR write bus
- busy  output  1  burst in progress

Behaviour:
- Clock is clk; reset is asynchronous and active-high.
- All outputs are registered.
- Reset values: write_valid=0, write_addr=0, write_data=0, busy=0, req_ready=1. FSM resets to IDLE.
- FSM states: IDLE, SEND.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch the whole descriptor, set index=0, go to SEND.
- SEND:
  - req_ready=0, busy=1.
  - Each cycle, drive write_valid=1 with the addr/data for the current index, then increment the index.
- Write order: index 0 STAGE, 1 ADDR, 2 FORMAT, 3 FILTER, 4 WRAP, 5 LOGDIM, 6+j MIPOFF(j) for j=0..VX_TEX_LOD_MAX. Total 7+VX_TEX_LOD_MAX writes; 18 when LOD_MAX=11.
- Latency: the first write (STAGE) is visible on the bus in the cycle after acceptance. Writes then continue on consecutive cycles with no bubbles.
- After the last MIPOFF write, the next cycle has write_valid=0 and busy=0, and the FSM returns to IDLE with req_ready=1. Minimum spacing between accepts is therefore burst length + 1 cycles.
- Data packing (all unused bits zero):
  - STAGE: stage zero-extended to 32 bits; with NUM_STAGES=1 the value is 0.
  - ADDR/FORMAT/FILTER/MIPOFF: the field sits in the low bits.
  - WRAP: wraps[0] at bit 0, wraps[1] at bit 16.
  - LOGDIM: logdims[0] at bit 0, logdims[1] at bit 16.
- Addresses are the VX_DCR_TEX_* macros; MIPOFF uses VX_DCR_TEX_MIPOFF(j).
- write_addr and write_data hold their last values when write_valid=0; consumers must ignore them.
- The DCR bus has no backpressure; the writer never stalls mid-burst.
- Inputs are sampled only at acceptance. Changes to req_* during SEND have no effect.
- Reset mid-burst aborts immediately: write_valid drops asynchronously and no partial write continues after reset deasserts.
- A req_valid that arrives in the same cycle reset deasserts is not accepted until the first clock edge with reset low.

Optional Feature:
- Macro: TEX_DCR_WRITER_DELTA_EN.
- When defined:
  - Keep a shadow copy of the last written value of every register per stage, plus a per-stage valid bit. Valid bits are cleared by reset.
  - The STAGE write is always issued.
  - Any other register whose shadow is valid and equal to the latched value is skipped with zero cycles consumed. The FSM advances to the next differing index in the same cycle.
  - The shadow is updated as each write issues.
  - A descriptor identical to the shadow produces exactly one write (STAGE).
- When undefined: no shadow state; every burst is the full 7+VX_TEX_LOD_MAX writes.

Test Plan:
- Reset, then descriptor stage=0, baseaddr=0x1000, format=2, filter=1, wraps={1,2}, logdims={5,4}, mipoffs[j]=j*0x100 -> 18 consecutive writes starting the cycle after accept: STAGE=0, ADDR=0x1000, FORMAT=2, FILTER=1, WRAP=0x00020001, LOGDIM=0x00040005, MIPOFF(j)=j*0x100. busy high 18 cycles; req_ready low for 18 cycles, then high.
- Hold req_valid continuously with two descriptors -> second accept occurs exactly 19 cycles after the first; no gap between writes within a burst; no write overlap between bursts.
- NUM_STAGES=4, stage=3 -> STAGE write data=0x3. Changing req_* during the burst does not alter any emitted data.
- Assert reset at burst write index 7 -> write_valid=0 immediately (before the next clk edge). After release, req_ready=1 and a new descriptor produces a full 18-write burst from STAGE.
- DELTA_EN: send the first descriptor twice to stage 0 -> second burst is the single STAGE write. Then change only format=3 -> exactly STAGE and FORMAT=3, over 2 cycles.
- DELTA_EN: same descriptor to stage 1 after stage 0 -> full 18-write burst (per-stage shadow invalid). Reset, then repeat -> full burst again.

Source files
------------

// File: rtl/vx_tex_dcr_writer_if.sv
// DCR write bus into the texture units, plus the texture DCR map and field widths it carries.
// Each define is guarded so an enclosing build can supply its own values.
`ifndef VX_TEX_LOD_MAX
`define VX_TEX_LOD_MAX 11
`endif
`ifndef VX_TEX_LOD_BITS
`define VX_TEX_LOD_BITS 4
`endif
`ifndef TEX_ADDR_BITS
`define TEX_ADDR_BITS 32
`endif
`ifndef TEX_FORMAT_BITS
`define TEX_FORMAT_BITS 3
`endif
`ifndef TEX_FILTER_BITS
`define TEX_FILTER_BITS 2
`endif
`ifndef TEX_WRAP_BITS
`define TEX_WRAP_BITS 2
`endif
`ifndef TEX_MIPOFF_BITS
`define TEX_MIPOFF_BITS 32
`endif
`ifndef VX_DCR_ADDR_BITS
`define VX_DCR_ADDR_BITS 12
`endif
`ifndef VX_DCR_DATA_BITS
`define VX_DCR_DATA_BITS 32
`endif
`ifndef VX_DCR_TEX_STAGE
`define VX_DCR_TEX_STAGE  12'h010
`define VX_DCR_TEX_ADDR   12'h011
`define VX_DCR_TEX_FORMAT 12'h012
`define VX_DCR_TEX_FILTER 12'h013
`define VX_DCR_TEX_WRAP   12'h014
`define VX_DCR_TEX_LOGDIM 12'h015
`define VX_DCR_TEX_MIPOFF(lod) (12'h016 + 12'(lod))
`endif

interface VX_dcr_bus_if;
    logic                         write_valid;
    logic [`VX_DCR_ADDR_BITS-1:0] write_addr;
    logic [`VX_DCR_DATA_BITS-1:0] write_data;

    modport master (output write_valid, write_addr, write_data);
    modport slave  (input  write_valid, write_addr, write_data);
endinterface

// File: rtl/vx_tex_dcr_writer.sv
// Serializes one texture-stage descriptor into the ordered DCR write burst (STAGE first).
// Optional TEX_DCR_WRITER_DELTA_EN: per-stage shadow that skips registers whose value is unchanged.
module vx_tex_dcr_writer #(
    parameter string INSTANCE_ID = "",
    parameter int    NUM_STAGES  = 1,
    localparam int   SW          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            req_valid,
    output logic                                            req_ready,
    input  logic [SW-1:0]                                   req_stage,
    input  logic [`TEX_ADDR_BITS-1:0]                       req_baseaddr,
    input  logic [`TEX_FORMAT_BITS-1:0]                     req_format,
    input  logic [`TEX_FILTER_BITS-1:0]                     req_filter,
    input  logic [1:0][`TEX_WRAP_BITS-1:0]                  req_wraps,
    input  logic [1:0][`VX_TEX_LOD_BITS-1:0]                req_logdims,
    input  logic [`VX_TEX_LOD_MAX:0][`TEX_MIPOFF_BITS-1:0]  req_mipoffs,
    VX_dcr_bus_if.master                                    dcr_bus_if,
    output logic                                            busy
);
    // state  | meaning
    // IDLE   | ready for a descriptor; on accept the STAGE write is launched directly
    // SEND   | issuing the remaining pending registers, one per cycle, lowest index first

    localparam int NREG = 6 + `VX_TEX_LOD_MAX;   // registers after STAGE
    localparam int RW   = $clog2(NREG);
    localparam int LW   = $clog2(`VX_TEX_LOD_MAX + 1);
    localparam int NSLOT = 2 ** SW;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    typedef logic [`VX_DCR_DATA_BITS-1:0] word_t;
    typedef logic [`VX_DCR_ADDR_BITS-1:0] addr_t;

    typedef struct packed {
        logic [`TEX_ADDR_BITS-1:0]                      baseaddr;
        logic [`TEX_FORMAT_BITS-1:0]                    format;
        logic [`TEX_FILTER_BITS-1:0]                    filter;
        logic [1:0][`TEX_WRAP_BITS-1:0]                 wraps;
        logic [1:0][`VX_TEX_LOD_BITS-1:0]               logdims;
        logic [`VX_TEX_LOD_MAX:0][`TEX_MIPOFF_BITS-1:0] mipoffs;
    } desc_t;

    // Register r maps to burst index r+1: ADDR, FORMAT, FILTER, WRAP, LOGDIM, MIPOFF(0..LOD_MAX).
    function automatic addr_t reg_addr(input logic [RW-1:0] r);
        addr_t a;
        case (r)
            RW'(0):  a = `VX_DCR_TEX_ADDR;
            RW'(1):  a = `VX_DCR_TEX_FORMAT;
            RW'(2):  a = `VX_DCR_TEX_FILTER;
            RW'(3):  a = `VX_DCR_TEX_WRAP;
            RW'(4):  a = `VX_DCR_TEX_LOGDIM;
            default: a = `VX_DCR_TEX_MIPOFF(r - RW'(5));
        endcase
        return a;
    endfunction

    function automatic word_t reg_data(input logic [RW-1:0] r, input desc_t d);
        word_t w;
        w = '0;
        case (r)
            RW'(0): w[`TEX_ADDR_BITS-1:0]   = d.baseaddr;
            RW'(1): w[`TEX_FORMAT_BITS-1:0] = d.format;
            RW'(2): w[`TEX_FILTER_BITS-1:0] = d.filter;
            RW'(3): begin
                w[`TEX_WRAP_BITS-1:0]       = d.wraps[0];
                w[16 +: `TEX_WRAP_BITS]     = d.wraps[1];
            end
            RW'(4): begin
                w[`VX_TEX_LOD_BITS-1:0]     = d.logdims[0];
                w[16 +: `VX_TEX_LOD_BITS]   = d.logdims[1];
            end
            default: w[`TEX_MIPOFF_BITS-1:0] = d.mipoffs[LW'(r - RW'(5))];
        endcase
        return w;
    endfunction

    logic [0:0]      state_q, state_d;
    logic            req_ready_q, req_ready_d;
    logic            busy_q, busy_d;
    logic            wvalid_q, wvalid_d;
    addr_t           waddr_q, waddr_d;
    word_t           wdata_q, wdata_d;
    logic [SW-1:0]   stage_q, stage_d;
    desc_t           desc_q, desc_d;
    logic [NREG-1:0] pend_q, pend_d;
    logic [NREG-1:0] req_diff;
    logic [RW-1:0]   cur_r;
    desc_t           req_desc;

`ifdef TEX_DCR_WRITER_DELTA_EN
    word_t            shadow_q [NSLOT][NREG];
    word_t            shadow_d [NSLOT][NREG];
    logic [NSLOT-1:0] shvalid_q, shvalid_d;
`endif

    assign req_desc = '{baseaddr: req_baseaddr, format: req_format, filter: req_filter,
                        wraps: req_wraps, logdims: req_logdims, mipoffs: req_mipoffs};

    always_comb begin
        req_diff = '1;
`ifdef TEX_DCR_WRITER_DELTA_EN
        for (int r = 0; r < NREG; r++) begin
            req_diff[r] = !shvalid_q[req_stage] ||
                          (reg_data(RW'(r), req_desc) != shadow_q[req_stage][r]);
        end
`endif
    end

    always_comb begin
        cur_r = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (pend_q[i]) cur_r = RW'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        wvalid_d    = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        stage_d     = stage_q;
        desc_d      = desc_q;
        pend_d      = pend_q;
`ifdef TEX_DCR_WRITER_DELTA_EN
        shadow_d    = shadow_q;
        shvalid_d   = shvalid_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (req_valid && req_ready_q) begin
                    stage_d     = req_stage;
                    desc_d      = req_desc;
                    pend_d      = req_diff;
                    wvalid_d    = 1'b1;
                    waddr_d     = `VX_DCR_TEX_STAGE;
                    wdata_d     = word_t'(req_stage);
                    busy_d      = 1'b1;
                    req_ready_d = 1'b0;
`ifdef TEX_DCR_WRITER_DELTA_EN
                    shvalid_d[req_stage] = 1'b1;
`endif
                    // An all-matching descriptor is just the STAGE write; stay in IDLE.
                    if (req_diff != '0) state_d = S_SEND;
                end
            end
            default: begin
                wvalid_d = 1'b1;
                waddr_d  = reg_addr(cur_r);
                wdata_d  = reg_data(cur_r, desc_q);
                pend_d   = pend_q & ~(NREG'(1) << cur_r);
`ifdef TEX_DCR_WRITER_DELTA_EN
                shadow_d[stage_q][cur_r] = wdata_d;
`endif
                if (pend_d == '0) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wvalid_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            stage_q     <= '0;
            desc_q      <= '0;
            pend_q      <= '0;
`ifdef TEX_DCR_WRITER_DELTA_EN
            shvalid_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            wvalid_q    <= wvalid_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            stage_q     <= stage_d;
            desc_q      <= desc_d;
            pend_q      <= pend_d;
`ifdef TEX_DCR_WRITER_DELTA_EN
            shvalid_q   <= shvalid_d;
`endif
        end
    end

`ifdef TEX_DCR_WRITER_DELTA_EN
    // Shadow contents are only meaningful under their valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end
`endif

    assign req_ready              = req_ready_q;
    assign busy                   = busy_q;
    assign dcr_bus_if.write_valid = wvalid_q;
    assign dcr_bus_if.write_addr  = waddr_q;
    assign dcr_bus_if.write_data  = wdata_q;

endmodule

// File: tb/tb_vx_tex_dcr_writer.sv
// Scoreboard bench for vx_tex_dcr_writer: expected writes are queued at acceptance and matched on the bus.
module tb_vx_tex_dcr_writer;
    localparam int NUM_STAGES = 4;
    localparam int LODM       = `VX_TEX_LOD_MAX;
    localparam int NW         = 7 + LODM;
    localparam int FB         = `TEX_FORMAT_BITS;
    localparam int FLB        = `TEX_FILTER_BITS;
    localparam int WB         = `TEX_WRAP_BITS;
    localparam int LB         = `VX_TEX_LOD_BITS;
`ifdef TEX_DCR_WRITER_DELTA_EN
    localparam bit DELTA = 1'b1;
`else
    localparam bit DELTA = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic                        req_valid = 1'b0;
    logic                        req_ready;
    logic                        busy;
    logic [1:0]                  req_stage = '0;
    logic [31:0]                 req_baseaddr = '0;
    logic [FB-1:0]               req_format = '0;
    logic [FLB-1:0]              req_filter = '0;
    logic [1:0][WB-1:0]          req_wraps = '0;
    logic [1:0][LB-1:0]          req_logdims = '0;
    logic [LODM:0][31:0]         req_mipoffs = '0;

    VX_dcr_bus_if bus ();

    vx_tex_dcr_writer #(.INSTANCE_ID("tex0"), .NUM_STAGES(NUM_STAGES)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_stage    (req_stage),
        .req_baseaddr (req_baseaddr),
        .req_format   (req_format),
        .req_filter   (req_filter),
        .req_wraps    (req_wraps),
        .req_logdims  (req_logdims),
        .req_mipoffs  (req_mipoffs),
        .dcr_bus_if   (bus),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
        logic        first;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_cyc[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          ncyc = 0;
    int          last_acc = 0;
    int          wr_count = 0;
    logic [31:0] m_sh [NUM_STAGES][NW];
    bit          m_shv [NUM_STAGES];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, ncyc);
        end
    endtask

    // Reference burst built from the descriptor currently on the req_* inputs.
    task automatic model_push();
        logic [11:0] a [NW];
        logic [31:0] d [NW];
        int          st;
        st   = int'(req_stage);
        a[0] = `VX_DCR_TEX_STAGE;  d[0] = 32'(req_stage);
        a[1] = `VX_DCR_TEX_ADDR;   d[1] = req_baseaddr;
        a[2] = `VX_DCR_TEX_FORMAT; d[2] = 32'(req_format);
        a[3] = `VX_DCR_TEX_FILTER; d[3] = 32'(req_filter);
        a[4] = `VX_DCR_TEX_WRAP;   d[4] = 32'(req_wraps[0]) | (32'(req_wraps[1]) << 16);
        a[5] = `VX_DCR_TEX_LOGDIM; d[5] = 32'(req_logdims[0]) | (32'(req_logdims[1]) << 16);
        for (int j = 0; j <= LODM; j++) begin
            a[6+j] = `VX_DCR_TEX_MIPOFF(j);
            d[6+j] = req_mipoffs[j];
        end
        exp_q.push_back('{addr: a[0], data: d[0], first: 1'b1});
        for (int k = 1; k < NW; k++) begin
            if (!(DELTA && m_shv[st] && m_sh[st][k] == d[k]))
                exp_q.push_back('{addr: a[k], data: d[k], first: 1'b0});
            m_sh[st][k] = d[k];
        end
        m_shv[st] = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (reset) begin
            exp_q.delete();
        end else begin
            check("write_valid", bus.write_valid, exp_q.size() != 0);
            if (bus.write_valid && exp_q.size() != 0) begin
                wr_count++;
                e = exp_q.pop_front();
                check("write_addr", bus.write_addr, e.addr);
                check("write_data", bus.write_data, e.data);
                if (e.first) check("first_latency", ncyc, last_acc + 1);
            end
            check("busy", busy, bus.write_valid);
            check("req_ready", req_ready, !bus.write_valid);
            if (req_valid && req_ready) begin
                last_acc = ncyc;
                acc_cyc.push_back(ncyc);
                model_push();
            end
        end
    end

    task automatic set_desc(input int st, input logic [31:0] base, input int fmt, input int flt,
                            input int w0, input int w1, input int l0, input int l1,
                            input logic [31:0] mip0, input logic [31:0] step);
        req_stage      = 2'(st);
        req_baseaddr   = base;
        req_format     = FB'(fmt);
        req_filter     = FLB'(flt);
        req_wraps[0]   = WB'(w0);
        req_wraps[1]   = WB'(w1);
        req_logdims[0] = LB'(l0);
        req_logdims[1] = LB'(l1);
        for (int j = 0; j <= LODM; j++) req_mipoffs[j] = 32'(mip0 + step * j);
    endtask

    task automatic wait_accept(input int n);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (acc_cyc.size() > n) break;
        end
        #1;
        check("accept_seen", acc_cyc.size() > n, 1'b1);
    endtask

    task automatic send();
        int n0;
        n0 = acc_cyc.size();
        req_valid = 1'b1;
        wait_accept(n0);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(posedge clk); #1;
            idle = (exp_q.size() == 0) && req_ready && !bus.write_valid;
        end
        check("idle_reached", idle, 1'b1);
    endtask

    task automatic clear_model();
        for (int s = 0; s < NUM_STAGES; s++) m_shv[s] = 1'b0;
    endtask

    initial begin
        int w0;
        int n0;
        clear_model();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_write_valid", bus.write_valid, 1'b0);
        check("rst_write_addr", bus.write_addr, 12'h0);
        check("rst_write_data", bus.write_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        reset = 1'b0;

        // Reference descriptor on stage 0
        set_desc(0, 32'h1000, 2, 1, 1, 2, 5, 4, 32'h0, 32'h100);
        w0 = wr_count;
        send();
        wait_idle();
        check("burst1_len", wr_count - w0, NW);

        // Back-to-back accepts with req_valid held, fields changed mid-burst
        set_desc(2, 32'h2222_0000, 5, 2, 3, 0, 7, 9, 32'h40, 32'h8);
        w0 = wr_count;
        n0 = acc_cyc.size();
        req_valid = 1'b1;
        wait_accept(n0);
        set_desc(3, 32'hABCD_0123, 1, 3, 2, 1, 10, 11, 32'h7000, 32'h10);
        wait_accept(n0 + 1);
        req_valid = 1'b0;
        set_desc(1, 32'hDEAD_BEEF, 7, 0, 0, 3, 15, 15, 32'hFFFF_0000, 32'h1);
        wait_idle();
        check("b2b_spacing", acc_cyc[n0+1] - acc_cyc[n0], NW + 1);
        check("b2b_len", wr_count - w0, 2 * NW);

        // Repeat reference descriptor, then a single-field change
        set_desc(0, 32'h1000, 2, 1, 1, 2, 5, 4, 32'h0, 32'h100);
        w0 = wr_count;
        send();
        wait_idle();
        check("repeat_len", wr_count - w0, DELTA ? 1 : NW);

        set_desc(0, 32'h1000, 3, 1, 1, 2, 5, 4, 32'h0, 32'h100);
        w0 = wr_count;
        send();
        wait_idle();
        check("format_only_len", wr_count - w0, DELTA ? 2 : NW);

        // Same descriptor aimed at a stage with no shadow yet
        set_desc(1, 32'h1000, 2, 1, 1, 2, 5, 4, 32'h0, 32'h100);
        w0 = wr_count;
        send();
        wait_idle();
        check("new_stage_len", wr_count - w0, NW);

        // Reset while burst index 7 is on the bus
        set_desc(1, 32'h5555_0000, 6, 2, 3, 3, 1, 2, 32'h900, 32'h4);
        send();
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_model();
        #1;
        check("midrst_write_valid", bus.write_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_req_ready", req_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("postrst_idle_valid", bus.write_valid, 1'b0);
        check("postrst_ready", req_ready, 1'b1);

        set_desc(0, 32'h1000, 2, 1, 1, 2, 5, 4, 32'h0, 32'h100);
        w0 = wr_count;
        send();
        wait_idle();
        check("postrst_len", wr_count - w0, NW);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
